// File: rtl/mem_fill_arbiter.sv
// Shared main-memory sequencer: write-through stores, then D-line fills, then I-line fills.
// A fill issues BLOCK_WORDS pipelined reads and counts returns; memory latency is not assumed.
module mem_fill_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = 8,
  parameter int WIDX_W      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              fill_we,
  output logic              fill_sel_d,
  output logic [WIDX_W-1:0] fill_widx,
  output logic [DATA_W-1:0] fill_data,
  output logic              i_fill_done,
  output logic              d_fill_done,
  output logic              d_wr_ack,
  output logic              busy
);

  // line base = byte address minus word index and byte-in-word bit
  localparam int BASE_W = ADDR_W - WIDX_W - 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_FILL  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [BASE_W-1:0] base_q,  base_d;
  logic              sel_d_q, sel_d_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  // iss_q MSB set means all reads of the line have been issued
  logic [WIDX_W:0]   iss_q,   iss_d;
  logic [WIDX_W-1:0] rcv_q,   rcv_d;

  logic issuing;
  assign issuing = (state_q == S_FILL) && !iss_q[WIDX_W];

  // next-state: arbitration in IDLE, issue/return counting in FILL
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    sel_d_d = sel_d_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    iss_d   = iss_q;
    rcv_d   = rcv_q;
    case (state_q)
      S_IDLE: begin
        if (d_wr) begin
          state_d = S_WRITE;
          waddr_d = d_wr_addr;
          wdata_d = d_wr_data;
        end else if (d_miss) begin
          state_d = S_FILL;
          base_d  = d_miss_addr[ADDR_W-1:WIDX_W+1];
          sel_d_d = 1'b1;
        end else if (i_miss) begin
          state_d = S_FILL;
          base_d  = i_miss_addr[ADDR_W-1:WIDX_W+1];
          sel_d_d = 1'b0;
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_FILL: begin
        if (issuing) iss_d = iss_q + 1'b1;
        if (mem_rvalid) begin
          rcv_d = rcv_q + 1'b1;
          if (&rcv_q) state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        iss_d   = '0;
        rcv_d   = '0;
      end
    endcase
  end

  // state and latched request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      sel_d_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      iss_q   <= '0;
      rcv_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      sel_d_q <= sel_d_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      iss_q   <= iss_d;
      rcv_q   <= rcv_d;
    end
  end

  // outputs decode from registered state so reset forces them low immediately
  assign mem_en      = (state_q == S_WRITE) || issuing;
  assign mem_wr      = (state_q == S_WRITE);
  assign mem_addr    = (state_q == S_WRITE) ? waddr_q :
                       issuing ? {base_q, iss_q[WIDX_W-1:0], 1'b0} : '0;
  assign mem_wdata   = (state_q == S_WRITE) ? wdata_q : '0;
  assign fill_we     = (state_q == S_FILL) && mem_rvalid;
  assign fill_sel_d  = sel_d_q;
  assign fill_widx   = rcv_q;
  assign fill_data   = fill_we ? mem_rdata : '0;
  assign i_fill_done = (state_q == S_DONE) && !sel_d_q;
  assign d_fill_done = (state_q == S_DONE) &&  sel_d_q;
  assign d_wr_ack    = (state_q == S_WRITE);
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Bench for mem_fill_arbiter: transaction-level model with timestamps, in-order memory with
// fixed or random latency, directed scenarios plus a randomized request phase.
module tb_mem_fill_arbiter;
  logic        clk = 0, rst_n = 1;
  logic        i_miss = 0, d_miss = 0, d_wr = 0;
  logic [15:0] i_miss_addr = 0, d_miss_addr = 0, d_wr_addr = 0, d_wr_data = 0;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_en, mem_wr, fill_we, fill_sel_d, i_fill_done, d_fill_done, d_wr_ack, busy;
  logic [15:0] mem_addr, mem_wdata, fill_data;
  logic [2:0]  fill_widx;

  mem_fill_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_wr(d_wr), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .fill_we(fill_we), .fill_sel_d(fill_sel_d), .fill_widx(fill_widx), .fill_data(fill_data),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done), .d_wr_ack(d_wr_ack), .busy(busy)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ntests = 0, nfail = 0;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- memory: in-order returns, data is a hash of the address
  typedef struct { logic [15:0] addr; int due; } rd_t;
  rd_t mq[$];
  int  lat_fixed = 4, last_due = 0;
  bit  inj = 0;
  function automatic logic [15:0] mdata(logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  initial begin
    mem_rvalid = 0; mem_rdata = 0;
    forever begin
      @(posedge clk); #1;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        mem_rvalid = 1; mem_rdata = mdata(mq[0].addr); mq.delete(0);
      end else begin
        mem_rvalid = inj; mem_rdata = 16'($urandom);
      end
    end
  end

  // ---------------- model: op 0 none, 1 store, 2 line fill; g = grant cycle
  int op = 0, g = 0, nrcv = 0, tdone = -1;
  logic [11:0] mbase;
  bit msel;
  logic [15:0] mwa, mwd;

  // DUT event logs for the literal checks
  int rd_addr[$], rd_cyc[$];
  int nfill = 0, n_idone = 0, n_ddone = 0, n_ack = 0, idone_cyc = -1, ddone_cyc = -1;
  int wr_cyc = -1, wr_addr = -1, wr_data = -1;
  bit saw_i = 0, saw_d = 0, saw_w = 0;

  function automatic int qa(int idx);
    return (rd_addr.size() > idx) ? rd_addr[idx] : -1;
  endfunction
  function automatic int qc(int idx);
    return (rd_cyc.size() > idx) ? rd_cyc[idx] : -1;
  endfunction
  task automatic clr_logs();
    rd_addr.delete(); rd_cyc.delete();
    nfill = 0; n_idone = 0; n_ddone = 0; n_ack = 0; idone_cyc = -1; ddone_cyc = -1;
    wr_cyc = -1; wr_addr = -1; wr_data = -1;
  endtask

  // per-cycle compare against the model, then advance the model
  initial forever begin
    int c, due;
    logic e_en, e_wr, e_we, e_id, e_dd, e_ack, e_busy;
    logic [15:0] e_addr, e_wd, e_fd;
    logic [2:0] e_widx;
    bit in_fill;
    @(negedge clk);
    c = cyc;
    e_en = 0; e_wr = 0; e_we = 0; e_id = 0; e_dd = 0; e_ack = 0; e_busy = 0;
    e_addr = 0; e_wd = 0; e_fd = 0; e_widx = 0;
    in_fill = rst_n && op == 2 && c > g;
    if (!rst_n) begin
      op = 0;
      chk("rst_addr", mem_addr, 0); chk("rst_wdata", mem_wdata, 0);
      chk("rst_widx", fill_widx, 0); chk("rst_fdata", fill_data, 0);
      chk("rst_sel", fill_sel_d, 0);
    end else if (op == 1 && c == g + 1) begin
      e_en = 1; e_wr = 1; e_addr = mwa; e_wd = mwd; e_ack = 1; e_busy = 1;
    end else if (in_fill) begin
      e_busy = 1;
      if (c == tdone) begin
        if (msel) e_dd = 1; else e_id = 1;
      end else begin
        if (c - g <= 8) begin e_en = 1; e_addr = {mbase, 3'(c - g - 1), 1'b0}; end
        if (mem_rvalid && nrcv < 8) begin
          e_we = 1; e_widx = 3'(nrcv); e_fd = mdata({mbase, 3'(nrcv), 1'b0});
        end
      end
    end
    chk("mem_en", mem_en, e_en);   chk("mem_wr", mem_wr, e_wr);
    chk("busy", busy, e_busy);     chk("fill_we", fill_we, e_we);
    chk("i_done", i_fill_done, e_id); chk("d_done", d_fill_done, e_dd);
    chk("wr_ack", d_wr_ack, e_ack);
    if (e_en) chk("mem_addr", mem_addr, e_addr);
    if (e_wr) chk("mem_wdata", mem_wdata, e_wd);
    if (e_we) begin chk("widx", fill_widx, e_widx); chk("fill_data", fill_data, e_fd); end
    if (in_fill) chk("fill_sel", fill_sel_d, msel);
    // logs and handshakes
    if (mem_en && !mem_wr) begin rd_addr.push_back(mem_addr); rd_cyc.push_back(c); end
    if (mem_en && mem_wr) begin wr_cyc = c; wr_addr = mem_addr; wr_data = mem_wdata; end
    if (fill_we) nfill++;
    if (i_fill_done) begin n_idone++; idone_cyc = c; saw_i = 1; end
    if (d_fill_done) begin n_ddone++; ddone_cyc = c; saw_d = 1; end
    if (d_wr_ack) begin n_ack++; saw_w = 1; end
    if (rst_n && mem_en && !mem_wr) begin
      due = c + (lat_fixed != 0 ? lat_fixed : int'($urandom_range(6, 3)));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{addr: mem_addr, due: due});
    end
    // advance model
    if (rst_n) begin
      if (in_fill && c != tdone && e_we) begin
        nrcv++;
        if (nrcv == 8) tdone = c + 1;
      end
      if ((op == 1 && c == g + 1) || (op == 2 && c == tdone)) op = 0;
      else if (op == 0) begin
        if (d_wr) begin op = 1; g = c; mwa = d_wr_addr; mwd = d_wr_data; end
        else if (d_miss) begin op = 2; g = c; mbase = d_miss_addr[15:4]; msel = 1; nrcv = 0; tdone = -1; end
        else if (i_miss) begin op = 2; g = c; mbase = i_miss_addr[15:4]; msel = 0; nrcv = 0; tdone = -1; end
      end
    end
  end

  // one cycle of requester behaviour: drop each request once its handshake was seen
  task automatic step();
    @(posedge clk); #1;
    if (saw_i) begin i_miss = 0; saw_i = 0; end
    if (saw_d) begin d_miss = 0; saw_d = 0; end
    if (saw_w) begin d_wr = 0; saw_w = 0; end
  endtask

  task automatic wait_clear(string nm, int n);
    int k = 0;
    while ((i_miss || d_miss || d_wr || op != 0) && k < n) begin step(); k++; end
    chk(nm, {29'b0, i_miss, d_miss, d_wr}, 0);
  endtask

  int t0;
  initial begin
    #2 rst_n = 0;
    repeat (3) step();
    chk("reset_busy", busy, 0); chk("reset_en", mem_en, 0);
    chk("reset_we", fill_we, 0); chk("reset_done", {i_fill_done, d_fill_done, d_wr_ack}, 0);
    rst_n = 1;
    // stray rvalid while idle must not write the array
    inj = 1; repeat (2) step(); inj = 0; step();
    chk("stray_rvalid", nfill, 0);

    // T1: single I miss, fixed latency 4
    clr_logs(); i_miss_addr = 16'h1236; i_miss = 1; t0 = cyc;
    wait_clear("t1_timeout", 60);
    chk("t1_nreads", rd_addr.size(), 8);
    chk("t1_first_addr", qa(0), 16'h1230); chk("t1_last_addr", qa(7), 16'h123E);
    chk("t1_first_cyc", qc(0), t0 + 1);    chk("t1_last_cyc", qc(7), t0 + 8);
    chk("t1_nfill", nfill, 8); chk("t1_ndone", n_idone, 1);
    chk("t1_done_cyc", idone_cyc, t0 + 13);
    chk("t1_busy_after", busy, 0);
    repeat (2) step();

    // T2: I and D miss together, D first
    clr_logs(); i_miss_addr = 16'h0100; d_miss_addr = 16'h4000; i_miss = 1; d_miss = 1; t0 = cyc;
    wait_clear("t2_timeout", 80);
    chk("t2_d_first", qa(0), 16'h4000); chk("t2_d_done_cyc", ddone_cyc, t0 + 13);
    chk("t2_i_addr", qa(8), 16'h0100);  chk("t2_i_start", qc(8), t0 + 15);
    chk("t2_ndone", {n_ddone[15:0], n_idone[15:0]}, 32'h0001_0001);
    repeat (2) step();

    // T3: store beats miss
    clr_logs(); d_wr_addr = 16'h2002; d_wr_data = 16'hBEEF; d_miss_addr = 16'h4010;
    d_wr = 1; d_miss = 1; t0 = cyc;
    wait_clear("t3_timeout", 60);
    chk("t3_wr_cyc", wr_cyc, t0 + 1); chk("t3_wr_addr", wr_addr, 16'h2002);
    chk("t3_wr_data", wr_data, 16'hBEEF); chk("t3_nack", n_ack, 1);
    chk("t3_fill_start", qc(0), t0 + 3); chk("t3_fill_addr", qa(0), 16'h4010);
    chk("t3_ndone", n_ddone, 1);
    repeat (2) step();

    // T4: variable latency
    lat_fixed = 0;
    clr_logs(); d_miss_addr = 16'h55A8; d_miss = 1; t0 = cyc;
    wait_clear("t4_timeout", 80);
    chk("t4_nfill", nfill, 8); chk("t4_addr", qa(0), 16'h55A0);
    chk("t4_done_lag", ddone_cyc, last_due + 1);
    repeat (2) step();
    lat_fixed = 4;

    // T5: reset during the 4th issued read
    clr_logs(); i_miss_addr = 16'h3338; i_miss = 1; t0 = cyc;
    repeat (4) step();
    chk("t5_reads_before", rd_addr.size(), 3);
    rst_n = 0; #1;
    chk("t5_async_en", mem_en, 0); chk("t5_async_busy", busy, 0);
    chk("t5_async_addr", mem_addr, 0);
    i_miss = 0;
    repeat (3) step();
    rst_n = 1;
    repeat (8) step();
    chk("t5_no_done", n_idone, 0); chk("t5_late_ignored", nfill, 0);
    clr_logs(); i_miss = 1;
    wait_clear("t5_timeout", 60);
    chk("t5_refetch_addr", qa(0), 16'h3330); chk("t5_nfill", nfill, 8);
    chk("t5_ndone", n_idone, 1);
    repeat (2) step();

    // T6: miss withdrawn mid-fill still completes
    clr_logs(); i_miss_addr = 16'h7770; i_miss = 1;
    repeat (3) step();
    chk("t6_issued", rd_addr.size(), 2);
    i_miss = 0;
    repeat (30) step();
    chk("t6_nfill", nfill, 8); chk("t6_ndone", n_idone, 1);

    // random traffic
    lat_fixed = 0;
    repeat (500) begin
      if (!d_wr && $urandom_range(9, 0) == 0) begin
        d_wr = 1; d_wr_addr = 16'($urandom); d_wr_data = 16'($urandom);
      end
      if (!d_miss && $urandom_range(15, 0) == 0) begin d_miss = 1; d_miss_addr = 16'($urandom); end
      if (!i_miss && $urandom_range(11, 0) == 0) begin i_miss = 1; i_miss_addr = 16'($urandom); end
      step();
    end
    wait_clear("rand_timeout", 400);
    repeat (10) step();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
